// File: rtl/sampler_register_bank.sv
// sampler_register_bank: parametrised codec/sampler register bank with byte-enabled control,
// sticky W1C status with interrupt masking, coherent counter snapshots and tear-free wide reads.
module sampler_register_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS = 5,
    parameter int NUM_CH = 4,
    parameter int NUM_STATUS = 8,
    parameter logic [DATA_WIDTH-1:0] CTRL_RESET = '0,
    parameter logic [DATA_WIDTH-1:0] VERSION = DATA_WIDTH'(32'h0002_0000)
) (
    input  logic                           s00_axi_aclk,
    input  logic                           s00_axi_aresetn,
    input  logic                           reg_wr_en,
    input  logic [ADDR_BITS-1:0]           reg_wr_addr,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic [DATA_WIDTH/8-1:0]        byte_enable,
    input  logic                           reg_rd_en,
    input  logic [ADDR_BITS-1:0]           reg_rd_addr,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           data_out_valid,
    output logic [DATA_WIDTH-1:0]          ctrl_out,
    output logic [DATA_WIDTH-1:0]          ctrl_pulse,
    input  logic [NUM_STATUS-1:0]          status_in,
    output logic                           irq_out,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_count_in,
    input  logic [2*DATA_WIDTH-1:0]        wide_data_in
);
    localparam logic [ADDR_BITS-1:0] A_VER = ADDR_BITS'(0);
    localparam logic [ADDR_BITS-1:0] A_CTRL = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] A_PULSE = ADDR_BITS'(2);
    localparam logic [ADDR_BITS-1:0] A_STAT = ADDR_BITS'(3);
    localparam logic [ADDR_BITS-1:0] A_IRQEN = ADDR_BITS'(4);
    localparam logic [ADDR_BITS-1:0] A_SNAP = ADDR_BITS'(5);
    localparam logic [ADDR_BITS-1:0] A_WLO = ADDR_BITS'(6);
    localparam logic [ADDR_BITS-1:0] A_WHI = ADDR_BITS'(7);
    localparam logic [ADDR_BITS-1:0] A_CH0 = ADDR_BITS'(8);

    logic [DATA_WIDTH-1:0]        ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0]        pulse_q, pulse_d;
    logic [NUM_STATUS-1:0]        status_q, status_d;
    logic [NUM_STATUS-1:0]        irq_en_q, irq_en_d;
    logic [NUM_STATUS-1:0]        prev_q, prev_d;
    logic [DATA_WIDTH-1:0]        snap_seq_q, snap_seq_d;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_snap_q, ch_snap_d;
    logic [DATA_WIDTH-1:0]        shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0]        data_out_q, data_out_d;
    logic                         valid_q, valid_d;

    logic [DATA_WIDTH-1:0] be_mask;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_ctrl, wr_pulse, wr_stat, wr_irqen, wr_snap, rd_wlo;

    always_comb begin
        be_mask = '0;
        for (int i = 0; i < DATA_WIDTH / 8; i++)
            be_mask[i*8 +: 8] = {8{byte_enable[i]}};
    end

    assign wr_ctrl  = reg_wr_en && reg_wr_addr == A_CTRL;
    assign wr_pulse = reg_wr_en && reg_wr_addr == A_PULSE;
    assign wr_stat  = reg_wr_en && reg_wr_addr == A_STAT;
    assign wr_irqen = reg_wr_en && reg_wr_addr == A_IRQEN;
    assign wr_snap  = reg_wr_en && reg_wr_addr == A_SNAP;
    assign rd_wlo   = reg_rd_en && reg_rd_addr == A_WLO;

    // Reads see only the flops, so a same-cycle write is never visible to its paired read.
    always_comb begin
        rd_data = '0;
        case (reg_rd_addr)
            A_VER:   rd_data = VERSION;
            A_CTRL:  rd_data = ctrl_q;
            A_STAT:  rd_data = DATA_WIDTH'(status_q);
            A_IRQEN: rd_data = DATA_WIDTH'(irq_en_q);
            A_SNAP:  rd_data = snap_seq_q;
            A_WLO:   rd_data = wide_data_in[DATA_WIDTH-1:0];
            A_WHI:   rd_data = shadow_q;
            default: rd_data = '0;
        endcase
        for (int n = 0; n < NUM_CH; n++)
            if (reg_rd_addr == A_CH0 + ADDR_BITS'(n))
                rd_data = ch_snap_q[n*DATA_WIDTH +: DATA_WIDTH];
    end

    // A rising edge ORs in after the W1C mask, so set wins over a same-cycle clear.
    always_comb begin
        ctrl_d     = wr_ctrl ? (ctrl_q & ~be_mask) | (data_in & be_mask) : ctrl_q;
        pulse_d    = wr_pulse ? data_in & be_mask : '0;
        prev_d     = status_in;
        status_d   = (status_q & ~(wr_stat ? data_in[NUM_STATUS-1:0] : '0)) | (status_in & ~prev_q);
        irq_en_d   = wr_irqen ? (irq_en_q & ~be_mask[NUM_STATUS-1:0]) | (data_in[NUM_STATUS-1:0] & be_mask[NUM_STATUS-1:0]) : irq_en_q;
        snap_seq_d = wr_snap ? snap_seq_q + DATA_WIDTH'(1) : snap_seq_q;
        ch_snap_d  = wr_snap ? ch_count_in : ch_snap_q;
        shadow_d   = rd_wlo ? wide_data_in[2*DATA_WIDTH-1:DATA_WIDTH] : shadow_q;
        data_out_d = reg_rd_en ? rd_data : data_out_q;
        valid_d    = reg_rd_en;
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ctrl_q     <= CTRL_RESET;
            pulse_q    <= '0;
            status_q   <= '0;
            irq_en_q   <= '0;
            prev_q     <= '0;
            snap_seq_q <= '0;
            ch_snap_q  <= '0;
            shadow_q   <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            pulse_q    <= pulse_d;
            status_q   <= status_d;
            irq_en_q   <= irq_en_d;
            prev_q     <= prev_d;
            snap_seq_q <= snap_seq_d;
            ch_snap_q  <= ch_snap_d;
            shadow_q   <= shadow_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign ctrl_out       = ctrl_q;
    assign ctrl_pulse     = pulse_q;
    assign irq_out        = |(status_q & irq_en_q);
endmodule

// File: tb/tb_sampler_register_bank.sv
// tb_sampler_register_bank: vector table plus scoreboarded reads for sampler_register_bank;
// a narrow second instance exercises snap_seq wrap-around.
module tb_sampler_register_bank;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_wr_en, reg_rd_en;
    logic [4:0]  reg_wr_addr, reg_rd_addr;
    logic [31:0] data_in, data_out, ctrl_out, ctrl_pulse;
    logic [3:0]  byte_enable;
    logic        data_out_valid, irq_out;
    logic [7:0]  status_in;
    logic [127:0] ch_count_in;
    logic [63:0] wide_data_in;

    logic        s_wr_en, s_rd_en, s_valid, s_irq;
    logic [3:0]  s_wr_addr, s_rd_addr, s_status;
    logic [7:0]  s_data_in, s_data_out, s_ctrl, s_pulse;
    logic [0:0]  s_be;
    logic [15:0] s_ch, s_wide;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] d;
        int          due;
        logic [4:0]  addr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [4:0]  ra;
        logic [31:0] rd_exp;
        logic [31:0] ctrl_exp;
        logic [31:0] pulse_exp;
    } vec_t;
    vec_t vt [17];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sampler_register_bank #(.CTRL_RESET(32'h0000_0005)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .data_in(data_in), .byte_enable(byte_enable),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .data_out(data_out), .data_out_valid(data_out_valid),
        .ctrl_out(ctrl_out), .ctrl_pulse(ctrl_pulse), .status_in(status_in), .irq_out(irq_out),
        .ch_count_in(ch_count_in), .wide_data_in(wide_data_in)
    );

    sampler_register_bank #(.DATA_WIDTH(8), .ADDR_BITS(4), .NUM_CH(2), .NUM_STATUS(4)) u_small (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .reg_wr_en(s_wr_en), .reg_wr_addr(s_wr_addr), .data_in(s_data_in), .byte_enable(s_be),
        .reg_rd_en(s_rd_en), .reg_rd_addr(s_rd_addr), .data_out(s_data_out), .data_out_valid(s_valid),
        .ctrl_out(s_ctrl), .ctrl_pulse(s_pulse), .status_in(s_status), .irq_out(s_irq),
        .ch_count_in(s_ch), .wide_data_in(s_wide)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] be,
                         input logic re, input logic [4:0] ra, input logic [31:0] ex);
        @(negedge clk);
        reg_wr_en = we;
        reg_wr_addr = wa;
        data_in = wd;
        byte_enable = be;
        reg_rd_en = re;
        reg_rd_addr = ra;
        if (re) sb.push_back('{ex, cyc + 1, ra});
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (data_out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid data_out=%h", data_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("rd_data@%0d", e.addr), {32'd0, data_out}, {32'd0, e.d});
                chk($sformatf("rd_latency@%0d", e.addr), 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        logic [127:0] snap;
        vt[0]  = '{1'b0, 5'd0,  32'h0,         4'h0, 1'b1, 5'd0,  32'h0002_0000, 32'h0000_0005, 32'h0};
        vt[1]  = '{1'b0, 5'd0,  32'h0,         4'h0, 1'b1, 5'd1,  32'h0000_0005, 32'h0000_0005, 32'h0};
        vt[2]  = '{1'b1, 5'd1,  32'hAABB_CCDD, 4'h5, 1'b0, 5'd0,  32'h0,         32'h00BB_00DD, 32'h0};
        vt[3]  = '{1'b0, 5'd0,  32'h0,         4'h0, 1'b1, 5'd1,  32'h00BB_00DD, 32'h00BB_00DD, 32'h0};
        vt[4]  = '{1'b1, 5'd2,  32'hFFFF_FFFF, 4'h1, 1'b1, 5'd2,  32'h0,         32'h00BB_00DD, 32'h0000_00FF};
        vt[5]  = '{1'b0, 5'd0,  32'h0,         4'h0, 1'b0, 5'd0,  32'h0,         32'h00BB_00DD, 32'h0};
        vt[6]  = '{1'b1, 5'd2,  32'h1234_5678, 4'hF, 1'b0, 5'd0,  32'h0,         32'h00BB_00DD, 32'h1234_5678};
        vt[7]  = '{1'b1, 5'd2,  32'h0000_AB00, 4'h2, 1'b0, 5'd0,  32'h0,         32'h00BB_00DD, 32'h0000_AB00};
        vt[8]  = '{1'b1, 5'd0,  32'hDEAD_BEEF, 4'hF, 1'b1, 5'd0,  32'h0002_0000, 32'h00BB_00DD, 32'h0};
        vt[9]  = '{1'b1, 5'd20, 32'hDEAD_BEEF, 4'hF, 1'b1, 5'd20, 32'h0,         32'h00BB_00DD, 32'h0};
        vt[10] = '{1'b0, 5'd0,  32'h0,         4'h0, 1'b1, 5'd31, 32'h0,         32'h00BB_00DD, 32'h0};
        vt[11] = '{1'b1, 5'd1,  32'h1122_3344, 4'hF, 1'b1, 5'd1,  32'h00BB_00DD, 32'h1122_3344, 32'h0};
        vt[12] = '{1'b0, 5'd0,  32'h0,         4'h0, 1'b1, 5'd1,  32'h1122_3344, 32'h1122_3344, 32'h0};
        vt[13] = '{1'b1, 5'd4,  32'h0000_FF08, 4'h1, 1'b1, 5'd4,  32'h0,         32'h1122_3344, 32'h0};
        vt[14] = '{1'b1, 5'd1,  32'hAABB_CCDD, 4'h0, 1'b1, 5'd4,  32'h0000_0008, 32'h1122_3344, 32'h0};
        vt[15] = '{1'b0, 5'd0,  32'h0,         4'h0, 1'b1, 5'd12, 32'h0,         32'h1122_3344, 32'h0};
        vt[16] = '{1'b0, 5'd0,  32'h0,         4'h0, 1'b0, 5'd0,  32'h0,         32'h1122_3344, 32'h0};

        rst_n = 1'b0;
        reg_wr_en = 0; reg_rd_en = 0; reg_wr_addr = 0; reg_rd_addr = 0; data_in = 0; byte_enable = 0;
        status_in = 0; ch_count_in = 0; wide_data_in = 0;
        s_wr_en = 0; s_rd_en = 0; s_wr_addr = 0; s_rd_addr = 0; s_data_in = 0; s_be = 0; s_status = 0; s_ch = 0; s_wide = 0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 64'(ctrl_out), 64'h5);
        chk("rst_pulse", 64'(ctrl_pulse), 64'h0);
        chk("rst_data_out", 64'(data_out), 64'h0);
        chk("rst_valid", 64'(data_out_valid), 64'h0);
        chk("rst_irq", 64'(irq_out), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].we, vt[i].wa, vt[i].wd, vt[i].be, vt[i].re, vt[i].ra, vt[i].rd_exp);
            post();
            chk($sformatf("vec%0d_ctrl", i), 64'(ctrl_out), 64'(vt[i].ctrl_exp));
            chk($sformatf("vec%0d_pulse", i), 64'(ctrl_pulse), 64'(vt[i].pulse_exp));
        end

        drive(1'b1, 5'd4, 32'h0, 4'hF, 1'b0, 5'd0, 32'h0); post();
        idle(); status_in = 8'h08; post();
        chk("stat_masked_irq", 64'(irq_out), 64'h0);
        idle(); status_in = 8'h00; post();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 32'h08); post();
        drive(1'b1, 5'd4, 32'h08, 4'h1, 1'b0, 5'd0, 32'h0); post();
        chk("irq_enabled", 64'(irq_out), 64'h1);
        drive(1'b1, 5'd3, 32'h08, 4'h0, 1'b1, 5'd3, 32'h08); post();
        chk("irq_after_w1c", 64'(irq_out), 64'h0);
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 32'h0); post();
        drive(1'b1, 5'd3, 32'h08, 4'h0, 1'b0, 5'd0, 32'h0); status_in = 8'h08; post();
        chk("irq_set_wins", 64'(irq_out), 64'h1);
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 32'h08); status_in = 8'h00; post();
        drive(1'b1, 5'd3, 32'hFF, 4'hF, 1'b0, 5'd0, 32'h0); post();
        chk("irq_final_clear", 64'(irq_out), 64'h0);

        snap = '0;
        for (int k = 0; k < 6; k++) begin
            drive(k == 3, 5'd5, 32'h0, 4'h0, 1'b0, 5'd0, 32'h0);
            for (int n = 0; n < 4; n++) ch_count_in[n*32 +: 32] = 32'((n + 1) << 24) + 32'(k);
            if (k == 3) snap = ch_count_in;
            post();
        end
        for (int n = 0; n < 4; n++) begin
            drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(8 + n), snap[n*32 +: 32]);
            ch_count_in = ch_count_in + 128'd1;
            post();
        end
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5, 32'd1); post();
        drive(1'b1, 5'd5, 32'h0, 4'h0, 1'b1, 5'd8, snap[31:0]);
        ch_count_in = {32'h4444_0000, 32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
        post();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd11, 32'h4444_0000); post();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5, 32'd2); post();

        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd6, 32'h3333_4444); wide_data_in = 64'h1111_2222_3333_4444; post();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd7, 32'h1111_2222); wide_data_in = 64'h5555_6666_7777_8888; post();
        idle(); post();
        chk("data_out_hold", 64'(data_out), 64'h1111_2222);
        chk("valid_low_idle", 64'(data_out_valid), 64'h0);
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd7, 32'h1111_2222); post();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd6, 32'h7777_8888); post();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd7, 32'h5555_6666); post();
        idle(); post();

        @(negedge clk);
        s_wr_en = 1'b1; s_wr_addr = 4'd5;
        repeat (255) @(negedge clk);
        s_wr_en = 1'b0; s_rd_en = 1'b1; s_rd_addr = 4'd5;
        post();
        chk("seq_all_ones", 64'({s_valid, s_data_out}), 64'h1FF);
        @(negedge clk);
        s_rd_en = 1'b0; s_wr_en = 1'b1;
        @(negedge clk);
        s_wr_en = 1'b0; s_rd_en = 1'b1;
        post();
        chk("seq_wrap", 64'({s_valid, s_data_out}), 64'h100);
        @(negedge clk);
        s_rd_en = 1'b0;

        drive(1'b1, 5'd2, 32'h0000_00F0, 4'hF, 1'b0, 5'd0, 32'h0); post();
        chk("pulse_before_rst", 64'(ctrl_pulse), 64'hF0);
        #2 rst_n = 1'b0;
        status_in = 8'h01;
        #1;
        chk("pulse_async_drop", 64'(ctrl_pulse), 64'h0);
        chk("ctrl_after_rst", 64'(ctrl_out), 64'h5);
        chk("data_out_rst", 64'({data_out_valid, data_out}), 64'h0);
        reg_wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 32'h01); post();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd1, 32'h5); status_in = 8'h00; post();
        chk("irq_en_after_rst", 64'(irq_out), 64'h0);
        idle(); post();
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
